// File: rtl/out_port_display.sv
// out_port_display: captures a 32-bit port value and scans it as 8 hex digits on a common-anode 7-seg display (clock, reset, data_in, freeze -> an_n, seg_n, dp_n, captured, update_pulse)
module out_port_display #(
    parameter int unsigned REFRESH_DIV   = 50000,
    parameter int unsigned BLANK_CYCLES  = 16,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic        freeze,
    output logic [7:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [31:0] captured,
    output logic        update_pulse
);
    localparam int unsigned CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK = CW'(BLANK_CYCLES);
    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [4:0]    sh;
    logic          blank, lead;
    logic [7:0]    an_d;
    logic [6:0]    seg_d;
    logic          dp_d;
    always_comb begin
        sh    = {idx, 2'b00};
        blank = cnt < BLANK;
        lead  = BLANK_LEADING && idx != 3'd0 && (captured >> sh) == 32'd0;
        an_d  = blank ? 8'hFF : ~(8'b1 << idx);
        seg_d = (blank || lead) ? 7'h7F : HEX[captured[sh +: 4]];
        dp_d  = !(!blank && idx == 3'd0 && freeze);
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            idx          <= '0;
            captured     <= '0;
            update_pulse <= 1'b0;
            an_n         <= 8'hFF;
            seg_n        <= 7'h7F;
            dp_n         <= 1'b1;
        end else begin
            cnt          <= (cnt == LAST) ? '0 : cnt + 1'b1;
            idx          <= (cnt == LAST) ? idx + 3'd1 : idx;
            captured     <= freeze ? captured : data_in;
            update_pulse <= !freeze && data_in != captured;
            an_n         <= an_d;
            seg_n        <= seg_d;
            dp_n         <= dp_d;
        end
    end
endmodule

// File: tb/tb_out_port_display.sv
// tb_out_port_display: randomized and directed check of out_port_display against a cycle-count reference model
module tb_out_port_display;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_in = '0;
    logic        freeze = 1'b0;
    logic [7:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [31:0] captured;
    logic        update_pulse;

    out_port_display #(.REFRESH_DIV(4), .BLANK_CYCLES(1), .BLANK_LEADING(1'b1)) dut (
        .clock(clock), .reset(reset), .data_in(data_in), .freeze(freeze),
        .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n),
        .captured(captured), .update_pulse(update_pulse)
    );

    always #5 clock = ~clock;

    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int          k;
    logic [31:0] cap_m;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, k);
        end
    endtask

    // Called just after a falling edge; drives inputs, predicts the next rising edge, checks after it.
    task automatic step(input logic [31:0] d, input logic f);
        int          slot, dig;
        logic [31:0] rest;
        logic [3:0]  nib;
        logic [7:0]  an_e;
        logic [6:0]  seg_e;
        logic        dp_e, up_e;
        logic [31:0] cap_e;
        data_in = d;
        freeze  = f;
        slot = k % 4;
        dig  = (k / 4) % 8;
        rest = cap_m >> (4 * dig);
        nib  = rest[3:0];
        if (slot < 1) begin
            an_e = 8'hFF; seg_e = 7'h7F; dp_e = 1'b1;
        end else begin
            an_e  = ~(8'd1 << dig);
            seg_e = (dig != 0 && rest == 0) ? 7'h7F : HEX[nib];
            dp_e  = !(dig == 0 && f);
        end
        cap_e = f ? cap_m : d;
        up_e  = !f && d != cap_m;
        @(posedge clock);
        #1;
        chk("an_n", 32'(an_n), 32'(an_e));
        chk("seg_n", 32'(seg_n), 32'(seg_e));
        chk("dp_n", 32'(dp_n), 32'(dp_e));
        chk("captured", captured, cap_e);
        chk("update_pulse", 32'(update_pulse), 32'(up_e));
        cap_m = cap_e;
        k++;
        @(negedge clock);
    endtask

    task automatic do_reset(input logic [31:0] d);
        #2;
        reset   = 1'b1;
        data_in = d;
        #1;
        chk("rst_an_n", 32'(an_n), 32'hFF);
        chk("rst_seg_n", 32'(seg_n), 32'h7F);
        chk("rst_dp_n", 32'(dp_n), 32'h1);
        chk("rst_captured", captured, 32'h0);
        chk("rst_update_pulse", 32'(update_pulse), 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        k     = 0;
        cap_m = '0;
    endtask

    initial begin
        logic [31:0] d;
        logic        f;
        k = 0;
        cap_m = '0;
        @(negedge clock);
        do_reset(32'h1234_5678);
        repeat (6) step(32'h1234_5678, 1'b0);
        do_reset(32'h1234_5678);
        repeat (4) step(32'h1234_5678, 1'b0);
        do_reset(32'h0000_00A5);
        repeat (33) step(32'h0000_00A5, 1'b0);
        repeat (36) step(32'hDEAD_BEEF, 1'b0);
        repeat (32) step(32'h0, 1'b0);
        repeat (3) step(32'h0000_0001, 1'b0);
        repeat (34) step(32'h0000_0002, 1'b1);
        repeat (3) step(32'h0000_0002, 1'b0);
        while (k % 4 != 3) step(32'h0000_0002, 1'b0);
        step(32'h8765_4321, 1'b0);
        repeat (8) step(32'h8765_4321, 1'b0);
        d = 32'hCAFE_0000;
        f = 1'b0;
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0: d = $urandom;
                1: d = $urandom >> $urandom_range(0, 31);
                default: ;
            endcase
            if ($urandom_range(0, 9) == 0) f = ~f;
            step(d, f);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
